fixed_point_sub_pipe: RTL and testbench

//  Pipelined fixed-point subtractor; the inverse-direction companion of the fixed-point adder.

---
 rtl/fxp_pkg.sv | 34 +++
 rtl/fxp_requant.sv | 51 +++++
 rtl/fixed_point_sub_pipe.sv | 116 +++++++++++
 tb/tb_fixed_point_sub_pipe.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers: width arithmetic and saturation limits
// for the fixed-point adder/subtractor family.
package fxp_pkg;

  typedef struct packed {
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
  } sat_lim_t;

  function automatic int fxp_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Aligned widths for the default Q4.5 - Q4.5 configuration; modules
  // with other formats derive their own from fxp_max.
  localparam int FW = fxp_max(5, 5);
  localparam int IW = fxp_max(4, 4) + 1;

  // Largest/smallest representable output code, as a signed integer in LSB units.
  function automatic sat_lim_t sat_limits(input logic sign, input int out_i, input int out_f);
    sat_lim_t r;
    int       ow;
    ow = out_i + out_f;
    if (sign) begin
      r.max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
      r.min_v = -(64'sd1 <<< (ow - 1));
    end else begin
      r.max_v = (64'sd1 <<< ow) - 64'sd1;
      r.min_v = 64'sd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fxp_requant.sv
// Combinational requantizer: scale a signed fixed-point value to Q(OUT_I.OUT_F),
// optionally round half-up, then saturate and flag.
module fxp_requant
  import fxp_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int IN_F  = 5,
  parameter int OUT_I = 4,
  parameter int OUT_F = 4,
  parameter bit ROUND = 1'b0
) (
  input  logic signed [IN_W-1:0]        d,
  input  logic                          sign,
  output logic        [OUT_I+OUT_F-1:0] q,
  output logic                          ovf,
  output logic                          unf
);

  localparam int OW  = OUT_I + OUT_F;
  localparam int SHR = (IN_F > OUT_F) ? IN_F - OUT_F : 0;
  localparam int SHL = (OUT_F > IN_F) ? OUT_F - IN_F : 0;
  // Headroom for the rounding carry, the left pad and the limit codes.
  localparam int WW  = fxp_max(IN_W + 2 + SHL, OW + 2);
  localparam logic signed [WW-1:0] RND =
    (ROUND && SHR > 0) ? (WW'(1) <<< ((SHR > 0) ? SHR - 1 : 0)) : '0;

  sat_lim_t            lim;
  logic signed [WW-1:0] ext;
  logic signed [WW-1:0] scaled;
  logic signed [WW-1:0] hi;
  logic signed [WW-1:0] lo;

  always_comb begin
    lim    = sat_limits(sign, OUT_I, OUT_F);
    hi     = lim.max_v[WW-1:0];
    lo     = lim.min_v[WW-1:0];
    ext    = WW'(d);
    scaled = ((ext + RND) >>> SHR) <<< SHL;
    q      = scaled[OW-1:0];
    ovf    = 1'b0;
    unf    = 1'b0;
    if (scaled > hi) begin
      q   = hi[OW-1:0];
      ovf = 1'b1;
    end else if (scaled < lo) begin
      q   = lo[OW-1:0];
      unf = 1'b1;
    end
  end

endmodule

// File: rtl/fixed_point_sub_pipe.sv
// Two-stage valid/ready fixed-point subtractor a - b with saturating requantization.
// Define FXP_SUB_ROUND_EN for round half-up instead of floor.
module fixed_point_sub_pipe
  import fxp_pkg::*;
#(
  parameter int I1    = 4,
  parameter int F1    = 5,
  parameter int I2    = 4,
  parameter int F2    = 5,
  parameter int OUT_I = 4,
  parameter int OUT_F = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [I1+F1-1:0]       a,
  input  logic [I2+F2-1:0]       b,
  input  logic                   sign_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_I+OUT_F-1:0] diff,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_cnt,
  output logic [CNT_W-1:0]       ovf_cnt,
  output logic [CNT_W-1:0]       unf_cnt
);

  localparam int STAGES = 2;
  localparam int DF     = fxp_max(F1, F2);
  localparam int DI     = fxp_max(I1, I2) + 1;
  localparam int DW     = DI + DF;
  localparam int OW     = OUT_I + OUT_F;
`ifdef FXP_SUB_ROUND_EN
  localparam bit ROUND  = 1'b1;
`else
  localparam bit ROUND  = 1'b0;
`endif

  logic [STAGES:1]     vld_pipe;
  logic                adv;
  logic [DW-1:0]       a_al;
  logic [DW-1:0]       b_al;
  logic signed [DW-1:0] diff_c;
  logic signed [DW-1:0] d1;
  logic                sign1;
  logic [OW-1:0]       rq;
  logic                rq_ovf;
  logic                rq_unf;
  logic                deliver;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign deliver   = out_valid & out_ready;

  // The extra integer bit keeps both signed and unsigned differences exact
  // when the aligned words are read as signed.
  always_comb begin
    a_al   = (sign_sub ? DW'(signed'(a)) : DW'(a)) << (DF - F1);
    b_al   = (sign_sub ? DW'(signed'(b)) : DW'(b)) << (DF - F2);
    diff_c = signed'(a_al - b_al);
  end

  fxp_requant #(
    .IN_W (DW),
    .IN_F (DF),
    .OUT_I(OUT_I),
    .OUT_F(OUT_F),
    .ROUND(ROUND)
  ) u_requant (
    .d   (d1),
    .sign(sign1),
    .q   (rq),
    .ovf (rq_ovf),
    .unf (rq_unf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      d1        <= '0;
      sign1     <= 1'b0;
      diff      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) begin
        d1    <= diff_c;
        sign1 <= sign_sub;
      end
      if (vld_pipe[1]) begin
        diff      <= rq;
        overflow  <= rq_ovf;
        underflow <= rq_unf;
      end else begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (deliver) begin
      if (overflow && ovf_cnt != '1)  ovf_cnt <= ovf_cnt + 1'b1;
      if (underflow && unf_cnt != '1) unf_cnt <= unf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fixed_point_sub_pipe.sv
// Directed bench for fixed_point_sub_pipe at default Q4.5 - Q4.5 -> Q4.4.
module tb_fixed_point_sub_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] a;
  logic [8:0] b;
  logic       sign_sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       overflow;
  logic       underflow;
  logic       clr_cnt;
  logic [7:0] ovf_cnt;
  logic [7:0] unf_cnt;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_deliv = 0;

  fixed_point_sub_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sign_sub (sign_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .overflow (overflow),
    .underflow(underflow),
    .clr_cnt  (clr_cnt),
    .ovf_cnt  (ovf_cnt),
    .unf_cnt  (unf_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (rst_n && out_valid && out_ready) n_deliv++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One isolated beat on an idle pipe with out_ready=1; checks latency and result.
  task automatic run1(input string tag, input logic [8:0] ta, input logic [8:0] tb_, input logic s,
                      input logic [7:0] ed, input logic eo, input logic eu);
    int lat;
    a = ta; b = tb_; sign_sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 6) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_ovf"}, overflow, eo);
    check({tag, "_unf"}, underflow, eu);
    tick();
  endtask

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sign_sub = 1'b0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) tick();
    check("rst_vld", out_valid, 0);
    check("rst_diff", diff, 8'h00);
    check("rst_flags", {overflow, underflow}, 2'b00);
    check("rst_cnt", {ovf_cnt, unf_cnt}, 16'h0000);
    check("rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    tick();

    run1("sgn_basic",  9'h020, 9'h010, 1'b1, 8'h08, 1'b0, 1'b0);
    run1("sgn_ovf",    9'h0E0, 9'h180, 1'b1, 8'h7F, 1'b1, 1'b0);
    check("ovf_cnt1", ovf_cnt, 8'd1);
    run1("sgn_unf",    9'h100, 9'h020, 1'b1, 8'h80, 1'b0, 1'b1);
    run1("sgn_min",    9'h100, 9'h000, 1'b1, 8'h80, 1'b0, 1'b0);
    run1("uns_neg",    9'h020, 9'h040, 1'b0, 8'h00, 1'b0, 1'b1);
    run1("uns_top",    9'h1E0, 9'h000, 1'b0, 8'hF0, 1'b0, 1'b0);
    check("unf_cnt2", unf_cnt, 8'd2);
    check("ovf_cnt_hold", ovf_cnt, 8'd1);

`ifdef FXP_SUB_ROUND_EN
    run1("rnd_lsb",    9'h001, 9'h000, 1'b1, 8'h01, 1'b0, 1'b0);
    run1("rnd_max",    9'h0FF, 9'h000, 1'b1, 8'h7F, 1'b1, 1'b0);
`else
    run1("rnd_lsb",    9'h001, 9'h000, 1'b1, 8'h00, 1'b0, 1'b0);
    run1("rnd_max",    9'h0FF, 9'h000, 1'b1, 8'h7F, 1'b0, 1'b0);
`endif

    // Mode switches between consecutive beats.
    a = 9'h020; b = 9'h040; sign_sub = 1'b0; in_valid = 1'b1;
    tick();
    sign_sub = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mode_u_diff", diff, 8'h00);
    check("mode_u_unf", underflow, 1);
    tick();
    check("mode_s_diff", diff, 8'hF0);
    check("mode_s_unf", underflow, 0);
    tick();

    // Backpressure: three stalled cycles, then drain in order.
    out_ready = 1'b0; base = n_deliv; sign_sub = 1'b1;
    a = 9'h040; b = 9'h020; in_valid = 1'b1;
    check("stall_rdy_a", in_ready, 1);
    tick();
    a = 9'h060; b = 9'h000;
    check("stall_rdy_b", in_ready, 1);
    tick();
    a = 9'h000; b = 9'h020;
    for (int i = 0; i < 3; i++) begin
      check("stall_rdy", in_ready, 0);
      check("stall_vld", out_valid, 1);
      check("stall_diff", diff, 8'h10);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("drain_b", diff, 8'h30);
    tick();
    check("drain_c", diff, 8'hF0);
    check("drain_c_vld", out_valid, 1);
    tick();
    check("drain_empty", out_valid, 0);
    check("drain_count", n_deliv - base, 3);

    // Synchronous reset with two beats in flight.
    a = 9'h040; b = 9'h020; in_valid = 1'b1;
    tick();
    a = 9'h060;
    tick();
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_cnt", {ovf_cnt, unf_cnt}, 16'h0000);
    check("mid_rst_diff", diff, 8'h00);
    rst_n = 1'b1;
    tick();
    check("mid_rst_drop", out_valid, 0);
    run1("post_rst", 9'h020, 9'h010, 1'b1, 8'h08, 1'b0, 1'b0);

    // clr_cnt on the delivery cycle of an overflow beat.
    a = 9'h0E0; b = 9'h180; sign_sub = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("clr_beat_ovf", overflow, 1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_wins", ovf_cnt, 8'd0);
    run1("cnt_again", 9'h0E0, 9'h180, 1'b1, 8'h7F, 1'b1, 1'b0);
    check("cnt_after_clr", ovf_cnt, 8'd1);

    // Counter sticks at all ones.
    a = 9'h0E0; b = 9'h180; in_valid = 1'b1;
    repeat (260) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("cnt_sat", ovf_cnt, 8'hFF);
    check("unf_untouched", unf_cnt, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
